stream_anti_underflow: RTL

- Parametrised successor to the fixed 32-bit anti-underflow stage on the Ethernet TX path.
- Buffers a LiteX-style stream (first/last/data/last_be/error) in a synchronous FIFO.
- Releases a packet to the source only when it can be sent without gaps: either the whole packet is buffered, or a programmable fill threshold is reached.
- If the FIFO still runs dry mid-packet, it terminates that packet with an error-marked abort word, drops the remainder at the sink, and counts the event.

---
 rtl/stream_anti_underflow.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stream_anti_underflow.sv
// Packet-aware anti-underflow FIFO for a first/last/data/last_be/error stream.
// Holds each packet back until it can leave gap-free; a mid-packet run-dry is cut with an error word.
module stream_anti_underflow #(
  parameter int DW        = 32,
  parameter int DEPTH     = 64,
  parameter int THRESHOLD = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic                     sink_first,
  input  logic                     sink_last,
  input  logic [DW-1:0]            sink_payload_data,
  input  logic [DW/8-1:0]          sink_payload_last_be,
  input  logic [DW/8-1:0]          sink_payload_error,
  output logic                     source_valid,
  input  logic                     source_ready,
  output logic                     source_first,
  output logic                     source_last,
  output logic [DW-1:0]            source_payload_data,
  output logic [DW/8-1:0]          source_payload_last_be,
  output logic [DW/8-1:0]          source_payload_error,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              underflow_count
);
  localparam int BL = DW / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = DW + 2 * BL + 2;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_count_q, pkt_count_d;
  logic          drop_q, drop_d;
  logic [15:0]   ucnt_q, ucnt_d;
  logic [WW-1:0] mem_q [DEPTH];

  logic [WW-1:0] head;
  logic [WW-1:0] wr_word;
  logic          head_last;
  logic          empty, full;
  logic          abort_now, discard;
  logic          wr_en, rd_en, abort_hs;
  logic          start;

  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[WW-2];
  assign wr_word   = {sink_first, sink_last, sink_payload_data,
                      sink_payload_last_be, sink_payload_error};

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign abort_now = (state_q == STREAM) && empty;
  assign discard   = drop_q || abort_now;

  // Drop mode and the abort cycle swallow sink words, so they never backpressure.
  assign sink_ready   = !sys_rst && (drop_q || abort_now || !full);
  assign source_valid = !sys_rst && (state_q == STREAM);

  assign wr_en    = sink_valid && sink_ready && !discard;
  assign rd_en    = source_valid && source_ready && !empty;
  assign abort_hs = source_valid && source_ready && abort_now;

  assign start = (pkt_count_q != '0)
              || ((THRESHOLD > 0) && (level_q >= LW'(THRESHOLD)))
              || full;

  assign source_first           = abort_now ? 1'b0 : head[WW-1];
  assign source_last            = abort_now ? 1'b1 : head_last;
  assign source_payload_data    = abort_now ? '0 : head[WW-3 -: DW];
  assign source_payload_last_be = abort_now ? '0 : head[2*BL-1 -: BL];
  assign source_payload_error   = abort_now ? '1 : head[BL-1:0];

  assign level           = level_q;
  assign underflow_count = ucnt_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + AW'(wr_en);
    rd_ptr_d    = rd_ptr_q + AW'(rd_en);
    level_d     = level_q + LW'(wr_en) - LW'(rd_en);
    pkt_count_d = pkt_count_q + LW'(wr_en && sink_last) - LW'(rd_en && head_last);
    drop_d      = drop_q;
    ucnt_d      = ucnt_q;

    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (abort_hs || (rd_en && head_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A last word discarded alongside the abort already closes the packet.
    if (abort_hs) begin
      drop_d = !(sink_valid && sink_last);
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end else if (drop_q && sink_valid && sink_ready && sink_last) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      drop_q      <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      drop_q      <= drop_d;
      ucnt_q      <= ucnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

endmodule
